wb_ctrl: RTL

Writeback controller for the 5-stage RISC-V core: it is the single write-side master of the integer register file. It merges ALU results from EX with load data returning from data memory, and aligns and sign/zero-extends loads. It tracks outstanding loads in a small in-order queue and raises an ID stall when a decoded instruction touches a register with a load still in flight.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/wb_load_queue.sv | 71 +++++++
 rtl/wb_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath defaults, load funct3 encodings
// and the outstanding-load queue entry used by the writeback controller.
package riscv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF    = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One in-flight load: where it writes, how to extract it, and its byte offset
  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
  } lq_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// In-order FIFO of outstanding loads. Besides the head entry it exposes every
// slot with a valid bit so the ID hazard check can compare against all of them.
module wb_load_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  lq_entry_t       i_wdata,
  input  logic            i_pop,
  output lq_entry_t       o_head,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count,
  output lq_entry_t       o_entries [DEPTH],
  output logic            o_valid   [DEPTH]
);

  lq_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_offs [DEPTH];

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

  // A push into a full queue is dropped even when a pop frees a slot this cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until marked valid, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_wdata;
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_offs[i]    = PW'(i) - r_rdPtr;
      o_entries[i] = r_mem[i];
      o_valid[i]   = (CW'(w_offs[i]) < r_count);
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: sole writer of the integer register file. Merges ALU
// results with returning load data, extracts/extends loads, and stalls ID on
// hazards against loads still in flight.
// Optional feature macro: WB_ALIGN_CHECK_EN (misaligned-load detection).
module wb_ctrl
  import riscv_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int LQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic [AW-1:0]    ex_rd_i,
  input  logic [WIDTH-1:0] ex_wdata_i,
  input  logic             ld_issue_i,
  input  logic [AW-1:0]    ld_rd_i,
  input  logic [2:0]       ld_funct3_i,
  input  logic [1:0]       ld_addr_lo_i,
  output logic             ld_full_o,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             mem_rready_o,
  input  logic [AW-1:0]    id_rs1_i,
  input  logic [AW-1:0]    id_rs2_i,
  input  logic [AW-1:0]    id_rd_i,
  output logic             stall_o,
  output logic [AW-1:0]    reg_waddr_o,
  output logic [WIDTH-1:0] reg_wdata_o,
  output logic             reg_wen_o,
  output logic             ld_misalign_o
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  lq_entry_t         w_newEntry;
  lq_entry_t         w_head;
  lq_entry_t         w_entries [LQ_DEPTH];
  logic              w_valid   [LQ_DEPTH];
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_pop;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [WIDTH-1:0]  w_ldData;
  logic              w_misalign;
  logic              w_stall;
  logic [AW-1:0]     r_waddr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_wen;

  assign w_newEntry = '{rd: ld_rd_i, funct3: ld_funct3_i, addr_lo: ld_addr_lo_i};

  wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (ld_issue_i),
    .i_wdata   (w_newEntry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // ALU results own the write port; memory holds its data until we take it
  assign mem_rready_o = !w_empty && !ex_valid_i;
  assign w_pop        = mem_rvalid_i && mem_rready_o;
  assign ld_full_o    = w_full;

  // Pick the addressed byte/halfword from the raw word and extend it
  always_comb begin
    w_byte = mem_rdata_i[{w_head.addr_lo, 3'b000} +: 8];
    w_half = mem_rdata_i[{w_head.addr_lo[1], 4'b0000} +: 16];
    case (w_head.funct3)
      F3_LB:   w_ldData = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_ldData = {{(WIDTH-8){1'b0}}, w_byte};
      F3_LH:   w_ldData = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_LHU:  w_ldData = {{(WIDTH-16){1'b0}}, w_half};
      default: w_ldData = mem_rdata_i;
    endcase
  end

`ifdef WB_ALIGN_CHECK_EN
  // Halfwords need an even offset, words (and unknown types) need offset 0
  always_comb begin
    case (w_head.funct3)
      F3_LB, F3_LBU: w_misalign = 1'b0;
      F3_LH, F3_LHU: w_misalign = w_head.addr_lo[0];
      default:       w_misalign = (w_head.addr_lo != 2'b00);
    endcase
  end

  logic r_misalign;

  // One-cycle misalign pulse aligned with the suppressed write slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_pop && w_misalign;
  end

  assign ld_misalign_o = r_misalign;
`else
  assign w_misalign    = 1'b0;
  assign ld_misalign_o = 1'b0;
`endif

  // Registered write port: ALU first, then an accepted load; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
    end else if (ex_valid_i) begin
      r_waddr <= ex_rd_i;
      r_wdata <= ex_wdata_i;
      r_wen   <= (ex_rd_i != '0);
    end else if (w_pop) begin
      r_waddr <= w_head.rd;
      r_wdata <= w_ldData;
      r_wen   <= (w_head.rd != '0) && !w_misalign;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;
  assign reg_wen_o   = r_wen;

  // Stall ID on RAW or WAW against any live load; entries leaving this cycle still count
  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].rd != '0) &&
          ((w_entries[i].rd == id_rs1_i) || (w_entries[i].rd == id_rs2_i) ||
           (w_entries[i].rd == id_rd_i)))
        w_stall = 1'b1;
    end
  end

  assign stall_o = w_stall;

endmodule
